// File: rtl/payload_char_feeder.sv
// Byte-stream front end for a bank of payload regex engines: maps bytes to character-class
// lines, steps the engines, drains them, and returns one match/length record per packet.
module payload_char_feeder #(
  parameter int NUM_CLASS = 34,
  parameter int NUM_ENG   = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [NUM_CLASS-1:0] cfg_data,
  output logic                 sod,
  output logic                 en,
  output logic [NUM_CLASS-1:0] cls,
  input  logic [NUM_ENG-1:0]   eng_match,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_ENG-1:0]   res_vec,
  output logic [15:0]          res_len
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, SOD, STREAM, FLUSH, DRAIN, CAPTURE, RESULT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NUM_CLASS-1:0] cls_tbl [256];
  logic [NUM_CLASS-1:0] cls_p1;
  logic                 vld_p1;
  logic                 accept;
  logic [15:0]          byte_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = s_valid & s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    res_valid  = 1'b0;
    en         = vld_p1;
    cls        = vld_p1 ? cls_p1 : '0;
    case (state)
      IDLE:    if (s_valid) state_next = SOD;
      SOD:     state_next = STREAM;
      STREAM: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_next = FLUSH;
      end
      FLUSH:   state_next = DRAIN;
      DRAIN: begin
        // Idle steps with no class bits let the engines settle on the tail of the packet.
        en  = 1'b1;
        cls = '0;
        if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) state_next = CAPTURE;
      end
      CAPTURE: state_next = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: class table lookup of the accepted byte; table contents are not reset.
  always_ff @(posedge clk) begin
    if (cfg_we) cls_tbl[cfg_addr] <= cfg_data;
    if (accept) cls_p1 <= cls_tbl[s_data];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sod    <= 1'b1;
    end else begin
      vld_p1 <= accept;
      sod    <= (state_next == SOD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == SOD)  byte_cnt <= '0;
      else if (accept)   byte_cnt <= sat_inc16(byte_cnt);
      if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vec <= '0;
      res_len <= '0;
    end else if (state == CAPTURE) begin
      res_vec <= eng_match;
      res_len <= byte_cnt;
    end
  end

endmodule

// File: tb/tb_payload_char_feeder.sv
// Bench for payload_char_feeder: directed cycle tables, hand-built corner sequences, and
// random packets checked against a timestamped expectation queue.
module tb_payload_char_feeder;
  localparam int NC = 34;
  localparam int NE = 8;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [7:0]    s_data;
  logic          cfg_we;
  logic [7:0]    cfg_addr;
  logic [NC-1:0] cfg_data;
  logic          sod, en;
  logic [NC-1:0] cls;
  logic [NE-1:0] eng_match;
  logic          res_valid, res_ready;
  logic [NE-1:0] res_vec;
  logic [15:0]   res_len;

  payload_char_feeder #(.NUM_CLASS(NC), .NUM_ENG(NE), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sod(sod), .en(en), .cls(cls), .eng_match(eng_match), .res_valid(res_valid),
    .res_ready(res_ready), .res_vec(res_vec), .res_len(res_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: class table image plus the expected en/cls activity keyed by cycle.
  logic [NC-1:0] mtab [256];
  typedef struct { int c; logic [NC-1:0] v; } exp_t;
  exp_t exp_q[$];
  bit   mon_on = 1'b0;

  always @(negedge clk) begin
    exp_t tmp;
    if (mon_on && !rst) begin
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        chk("en_step", en, 1);
        chk("cls", cls, exp_q[0].v);
        tmp = exp_q.pop_front();
      end else begin
        chk("en_idle", en, 0);
      end
    end
  end

  task automatic cfg_write(input logic [7:0] a, input logic [NC-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mtab[a] = d;
  endtask

  task automatic finish_res(input int p0, input bit lat, input int n, input logic [NE-1:0] em,
                            input int hold, input bit early);
    int w = 0;
    int exp_len = (n > 65535) ? 65535 : n;
    @(negedge clk);
    while (!res_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("res_seen", res_valid, 1);
    if (!res_valid) return;
    if (lat) chk("res_latency", cyc, p0 + 4 + n + DC);
    chk("en_pending", exp_q.size(), 0);
    chk("res_len", res_len, exp_len);
    chk("res_vec", res_vec, em);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (early) begin s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0; end
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_vec", res_vec, em);
      chk("hold_len", res_len, exp_len);
      if (early) chk("early_not_ready", s_ready, 0);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    chk("res_drop", res_valid, 0);
    chk("idle_not_ready", s_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input int n, input int gap_pct, input int hold, input bit lat, input bit early);
    logic [NE-1:0] em;
    exp_t e;
    int p0, i, guard;
    bit acc;
    em = NE'($urandom); eng_match = em; p0 = cyc;
    if (!s_valid) s_data = 8'($urandom);
    s_valid = 1'b1; s_last = (n == 1);
    i = 0; guard = 0;
    while (i < n && guard < 4 * n + 100) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (acc) begin
        e.c = cyc + 1; e.v = mtab[s_data]; exp_q.push_back(e);
        if (s_last) for (int k = 0; k < DC; k++) begin
          e.c = cyc + 2 + k; e.v = '0; exp_q.push_back(e);
        end
        i++;
      end
      @(posedge clk); #1;
      if (acc || !s_valid) begin
        if (i < n && $urandom_range(99) >= gap_pct) begin
          s_valid = 1'b1; s_data = 8'($urandom); s_last = (i == n - 1);
        end else begin
          s_valid = 1'b0; s_last = 1'b0;
        end
      end
      guard++;
    end
    chk("pkt_accepted", i, n);
    s_valid = 1'b0; s_last = 1'b0;
    finish_res(p0, lat, n, em, hold, early);
  endtask

  typedef struct {
    logic sv; logic [7:0] d; logic l; logic rr;
    logic e_sod; logic e_en; logic [NC-1:0] e_cls; logic e_rdy; logic e_rv;
  } vec_t;
  vec_t tv[16];

  function automatic vec_t mk(logic sv, logic [7:0] d, logic l, logic rr, logic so, logic e,
                              logic [NC-1:0] c, logic rd, logic rv);
    vec_t t;
    t.sv = sv; t.d = d; t.l = l; t.rr = rr;
    t.e_sod = so; t.e_en = e; t.e_cls = c; t.e_rdy = rd; t.e_rv = rv;
    return t;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int p0;
    rst = 1'b1; s_valid = 0; s_data = 0; s_last = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    eng_match = 0; res_ready = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_sod", sod, 1);
    chk("rst_ready", s_ready, 0);
    chk("rst_en", en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_vec", res_vec, 0);
    chk("rst_res_len", res_len, 0);
    rst = 1'b0;
    @(negedge clk); chk("sod_hold_until_edge", sod, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("sod_drop", sod, 0);
    @(posedge clk); #1;

    for (int a = 0; a < 256; a++) cfg_write(8'(a), '0);
    cfg_write(8'h61, NC'(2));
    cfg_write(8'h2F, NC'(256));

    // "a/a" packet cycle by cycle, engines report A5, consumer stalls five cycles.
    tv[0]  = mk(1, 8'h61, 0, 0, 0, 0, '0, 0, 0);
    tv[1]  = mk(1, 8'h61, 0, 0, 1, 0, '0, 0, 0);
    tv[2]  = mk(1, 8'h61, 0, 0, 0, 0, '0, 1, 0);
    tv[3]  = mk(1, 8'h2F, 0, 0, 0, 1, NC'(2), 1, 0);
    tv[4]  = mk(1, 8'h61, 1, 0, 0, 1, NC'(256), 1, 0);
    tv[5]  = mk(0, 8'h00, 0, 0, 0, 1, NC'(2), 0, 0);
    tv[6]  = mk(0, 8'h00, 0, 0, 0, 1, '0, 0, 0);
    tv[7]  = mk(0, 8'h00, 0, 0, 0, 1, '0, 0, 0);
    tv[8]  = mk(0, 8'h00, 0, 0, 0, 0, '0, 0, 0);
    for (int k = 9; k < 14; k++) tv[k] = mk(0, 8'h00, 0, 0, 0, 0, '0, 0, 1);
    tv[14] = mk(0, 8'h00, 0, 1, 0, 0, '0, 0, 1);
    tv[15] = mk(0, 8'h00, 0, 0, 0, 0, '0, 0, 0);
    eng_match = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      s_valid = tv[k].sv; s_data = tv[k].d; s_last = tv[k].l; res_ready = tv[k].rr;
      @(negedge clk);
      chk($sformatf("v%0d_sod", k), sod, tv[k].e_sod);
      chk($sformatf("v%0d_en", k), en, tv[k].e_en);
      if (tv[k].e_en) chk($sformatf("v%0d_cls", k), cls, tv[k].e_cls);
      chk($sformatf("v%0d_ready", k), s_ready, tv[k].e_rdy);
      chk($sformatf("v%0d_res_valid", k), res_valid, tv[k].e_rv);
      if (tv[k].e_rv) begin
        chk($sformatf("v%0d_res_vec", k), res_vec, 8'hA5);
        chk($sformatf("v%0d_res_len", k), res_len, 3);
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b0;

    // Table write colliding with a lookup of the same byte: old entry first, new entry next.
    cfg_write(8'h41, NC'(8));
    p0 = cyc; eng_match = 8'h3C;
    s_valid = 1; s_data = 8'h41; s_last = 0;
    @(negedge clk); chk("col_idle_ready", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("col_sod", sod, 1);
    @(posedge clk); #1; cfg_we = 1; cfg_addr = 8'h41; cfg_data = NC'(32);
    @(negedge clk); chk("col_ready", s_ready, 1);
    @(posedge clk); #1; cfg_we = 0; mtab[8'h41] = NC'(32); s_last = 1;
    @(negedge clk); chk("col_old_en", en, 1); chk("col_old_cls", cls, NC'(8));
    @(posedge clk); #1; s_valid = 0; s_last = 0;
    @(negedge clk); chk("col_new_en", en, 1); chk("col_new_cls", cls, NC'(32));
    @(posedge clk); #1;
    finish_res(p0, 1, 2, 8'h3C, 1, 0);

    mon_on = 1'b1;
    run_pkt(4, 50, 2, 0, 1);
    run_pkt(3, 0, 0, 0, 0);
    run_pkt(1, 0, 1, 1, 0);

    // Reset in the middle of a packet aborts without a result.
    mon_on = 1'b0;
    s_valid = 1; s_data = 8'($urandom); s_last = 0;
    repeat (4) @(posedge clk); #1;
    @(negedge clk); chk("abort_pre_ready", s_ready, 1);
    rst = 1'b1; #1;
    chk("abort_sod", sod, 1);
    chk("abort_ready", s_ready, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_en", en, 0);
    @(posedge clk); #1; rst = 1'b0; s_valid = 0;
    @(negedge clk); chk("abort_sod_hold", sod, 1);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_no_result", res_valid, 0);
      chk("abort_sod_low", sod, 0);
    end
    @(posedge clk); #1;
    mon_on = 1'b1;
    run_pkt(5, 0, 0, 1, 0);

    for (int a = 0; a < 256; a++) begin
      r = {$urandom, $urandom};
      cfg_write(8'(a), r[NC-1:0]);
    end
    for (int p = 0; p < 12; p++) begin
      int gap = ($urandom_range(1) == 1) ? 30 : 0;
      for (int k = 0; k < 3; k++) begin
        r = {$urandom, $urandom};
        cfg_write(8'($urandom), r[NC-1:0]);
      end
      run_pkt($urandom_range(24, 1), gap, $urandom_range(3), gap == 0, 0);
    end

    run_pkt(70000, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
